// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl: unsigned 8x8 multiply sequenced over four cycles through one 4x4 array multiplier,
// with valid/ready handshakes on operands and product.
module multiplier_4_x_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  assign p_o = {4'd0, a_i & {4{b_i[0]}}} + {3'd0, a_i & {4{b_i[1]}}, 1'b0}
             + {2'd0, a_i & {4{b_i[2]}}, 2'd0} + {1'b0, a_i & {4{b_i[3]}}, 3'd0};
endmodule

module mult8_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_product,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q;
  logic [7:0]       a_q, b_q, pp;
  logic [3:0]       ma, mb, sh;
  logic [1:0]       idx_q;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  // idx bit 0 picks the multiplicand nibble, bit 1 the multiplier nibble
  assign ma = idx_q[0] ? a_q[7:4] : a_q[3:0];
  assign mb = idx_q[1] ? b_q[7:4] : b_q[3:0];
  assign sh = idx_q == 2'd0 ? 4'd0 : idx_q == 2'd3 ? 4'd8 : 4'd4;
  multiplier_4_x_4 u_mul (.a_i(ma), .b_i(mb), .p_o(pp));
  assign acc_d = acc_q + ({8'd0, pp} << sh);
  assign ops_d = ops_q + CNT_W'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      ops_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (abort && state_q != IDLE) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && !abort) begin
          a_q     <= in_a;
          b_q     <= in_b;
          acc_q   <= '0;
          idx_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= DONE;
        end
        DONE: if (out_ready) begin
          ops_q   <= ops_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready    = state_q == IDLE;
  assign out_valid   = state_q == DONE;
  assign busy        = state_q != IDLE;
  assign out_product = acc_q;
  assign ops_done    = ops_q;
endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// tb_mult8_seq_ctrl: directed vector table plus corner sequences and a random run against a*b.
module tb_mult8_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        in_ready, out_valid, busy, in_ready_w, out_valid_w, busy_w;
  logic [15:0] out_product, prod_w, ops16;
  logic [1:0]  ops2;
  int          passed = 0, total = 0, exp_cnt = 0;

  mult8_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .busy(busy), .ops_done(ops16));
  mult8_seq_ctrl #(.CNT_W(2)) u_w (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready_w), .in_a(in_a), .in_b(in_b), .abort(abort), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_product(prod_w), .busy(busy_w), .ops_done(ops2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_cnt();
    chk("ops_done", 32'(ops16), 32'(exp_cnt[15:0]));
    chk("ops_done_w2", 32'(ops2), 32'(exp_cnt[1:0]));
  endtask

  task automatic chk_reset_outs(input string nm);
    chk(nm, {in_ready, out_valid, busy, out_product, ops16, ops2},
        {1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'h0});
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", {busy, in_ready}, 2'b10);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input int bp);
    int n = 0;
    out_ready = 1'b0;
    accept(a, b);
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("latency", n, 4);
    chk("product", out_product, exp);
    chk("product_w", prod_w, exp);
    for (int i = 0; i < bp; i++) begin
      in_valid = ~in_valid;
      in_a = 8'($urandom);
      tick();
      chk("bp_hold", {out_valid, in_ready, busy, out_product}, {3'b101, exp});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt++;
    chk_cnt();
    chk("idle_after_hs", {in_ready, out_valid, busy}, 3'b100);
  endtask

  task automatic abort_calc(input logic [7:0] a, input logic [7:0] b, input int k);
    accept(a, b);
    repeat (k) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_calc_idle", {in_ready, out_valid, busy}, 3'b100);
    repeat (4) begin
      tick();
      chk("abort_calc_no_valid", out_valid, 0);
    end
    chk_cnt();
  endtask

  task automatic abort_done(input logic [7:0] a, input logic [7:0] b);
    out_ready = 1'b0;
    accept(a, b);
    repeat (4) tick();
    chk("abort_done_valid", out_valid, 1);
    out_ready = 1'b1;
    abort = 1'b1;
    tick();
    out_ready = 1'b0;
    abort = 1'b0;
    chk("abort_done_idle", {in_ready, out_valid, busy}, 3'b100);
    chk_cnt();
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          bp;
  } vec_t;
  vec_t vt[6];

  initial begin
    int acc_c[$];
    int hs;
    logic [7:0] ra, rb;
    vt[0] = '{8'h12, 8'h34, 16'h03A8, 0};
    vt[1] = '{8'hFF, 8'hFF, 16'hFE01, 2};
    vt[2] = '{8'h00, 8'hAB, 16'h0000, 0};
    vt[3] = '{8'hF0, 8'h0F, 16'h0E10, 1};
    vt[4] = '{8'h01, 8'h80, 16'h0080, 0};
    vt[5] = '{8'h12, 8'h34, 16'h03A8, 10};

    tick();
    chk_reset_outs("reset_state");
    rst_n = 1'b1;
    tick();
    chk_reset_outs("idle_after_reset");

    // six ops take the 2-bit counter through 1,2,3,0,1,2
    for (int i = 0; i < 6; i++) run_op(vt[i].a, vt[i].b, vt[i].p, vt[i].bp);
    repeat (3) tick();
    chk_cnt();

    // back-to-back with in_valid held high
    in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 25) in_valid = 1'b0;
      if (in_valid && in_ready) acc_c.push_back(c);
      if (out_valid) begin
        chk("b2b_product", out_product, 16'hFE01);
        exp_cnt++;
      end
      tick();
    end
    out_ready = 1'b0;
    chk("b2b_accepts", acc_c.size(), 5);
    for (int i = 1; i < acc_c.size(); i++) chk("b2b_spacing", acc_c[i] - acc_c[i-1], 6);
    chk_cnt();

    abort_calc(8'h55, 8'h66, 2);
    abort_done(8'h77, 8'h88);
    run_op(8'h0A, 8'h0B, 16'h006E, 0);

    // abort while idle blocks the accept
    in_valid = 1'b1; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_idle_no_accept", {in_ready, busy}, 2'b10);

    // reset mid-CALC, then mid-DONE with out_ready high
    accept(8'h33, 8'h44);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    chk_reset_outs("reset_mid_calc");
    run_op(8'h02, 8'h03, 16'h0006, 0);
    accept(8'h99, 8'h99);
    repeat (4) tick();
    chk("pre_reset_done", out_valid, 1);
    out_ready = 1'b1; rst_n = 1'b0;
    tick();
    out_ready = 1'b0; rst_n = 1'b1;
    exp_cnt = 0;
    chk_reset_outs("reset_mid_done");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      hs = int'($urandom_range(0, 19));
      if (hs < 2) abort_calc(ra, rb, int'($urandom_range(0, 3)));
      else if (hs == 2) abort_done(ra, rb);
      else run_op(ra, rb, 16'(ra) * 16'(rb), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
